// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: opcode decode field,
// the two opcodes the sequencer reacts to, and the FSM state encoding.
package prog_sequencer_pkg;

    // Opcode field inside an instruction word
    localparam int OP_LSB = 6;
    localparam int OP_MSB = 8;

    typedef logic [OP_MSB-OP_LSB:0] opcode_t;

    localparam opcode_t OP_MVI  = 3'b001;  // two-word instruction (immediate follows)
    localparam opcode_t OP_HALT = 3'b111;  // end of program

    typedef enum logic [3:0] {
        S_IDLE,
        S_F_OP,
        S_L_OP,
        S_F_IMM,
        S_L_IMM,
        S_ISSUE,
        S_WAIT,
        S_HALTED,
        S_ERROR
    } seq_state_t;

    // Extract the opcode from the low bits of an instruction word
    function automatic opcode_t decode_op(input logic [OP_MSB:0] word_low);
        return word_low[OP_MSB:OP_LSB];
    endfunction

    // Idle-like states accept a new Start; every other state is busy
    function automatic logic is_busy_state(input seq_state_t s);
        return !(s inside {S_IDLE, S_HALTED, S_ERROR});
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Clearable up-counter with a terminal-count flag. It counts the cycles
// the sequencer has spent waiting for the processor's Done and stops at
// TIMEOUT-1 so it can never wrap back to a harmless value.
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count wait cycles; clear has priority, saturate at the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of block order.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches instructions from a synchronous ROM starting at
// address 0, issues each one to the processor with a single-cycle Run pulse,
// holds the mvi immediate on Din until Done, and stops on HALT or when the
// processor fails to answer within TIMEOUT wait cycles.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              Start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] proc_din,
    output logic              Run,
    input  logic              Done,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic [7:0]        instr_count
);

    seq_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] op_reg;
    logic [DATA_W-1:0] imm_reg;

    opcode_t rdata_op;
    logic    held_is_mvi;
    logic    wdog_clear;
    logic    wdog_inc;
    logic    wdog_terminal;

    assign rdata_op    = decode_op(mem_rdata[OP_MSB:0]);
    assign held_is_mvi = (decode_op(op_reg[OP_MSB:0]) == OP_MVI);

    // The watchdog restarts on every issue and runs only while Done is absent
    assign wdog_clear = (state == S_ISSUE);
    assign wdog_inc   = (state == S_WAIT) && !Done;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (Resetn),
        .clear    (wdog_clear),
        .inc      (wdog_inc),
        .terminal (wdog_terminal)
    );

    // Sequencer FSM together with the pc, instruction and immediate registers
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state       <= S_IDLE;
            pc          <= '0;
            op_reg      <= '0;
            imm_reg     <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                // Start is only honoured when nothing is in flight; restarting
                // from HALTED/ERROR clears the flag simply by leaving the state.
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (Start) begin
                        pc          <= '0;
                        instr_count <= '0;
                        state       <= S_F_OP;
                    end
                end

                // ROM is presenting pc this cycle; data arrives next cycle
                S_F_OP: state <= S_L_OP;

                // pc always advances, so after HALT it points past the HALT word
                S_L_OP: begin
                    op_reg <= mem_rdata;
                    pc     <= pc + ADDR_W'(1);
                    if (rdata_op == OP_HALT) begin
                        state <= S_HALTED;
                    end else if (rdata_op == OP_MVI) begin
                        state <= S_F_IMM;
                    end else begin
                        state <= S_ISSUE;
                    end
                end

                // pc already points at the immediate (wraps to 0 at the top)
                S_F_IMM: state <= S_L_IMM;

                S_L_IMM: begin
                    imm_reg <= mem_rdata;
                    pc      <= pc + ADDR_W'(1);
                    state   <= S_ISSUE;
                end

                S_ISSUE: state <= S_WAIT;

                S_WAIT: begin
                    if (Done) begin
                        if (instr_count != 8'hFF) begin
                            instr_count <= instr_count + 8'd1;
                        end
                        state <= S_F_OP;
                    end else if (wdog_terminal) begin
                        state <= S_ERROR;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr = pc;

    // Processor-facing outputs decoded purely from registered state
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        proc_din = '0;
        Run      = 1'b0;
        case (state)
            S_ISSUE: begin
                Run      = 1'b1;
                proc_din = op_reg;
            end
            S_WAIT: begin
                if (held_is_mvi) begin
                    proc_din = imm_reg;
                end
            end
            default: ;
        endcase
    end

    assign busy        = is_busy_state(state);
    assign halted      = (state == S_HALTED);
    assign timeout_err = (state == S_ERROR);

endmodule
